mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Arbiter and sequencer for the single-port data memory shared by the instruction-fetch stage (read-only) and the memory cycle stage (read/write). Grants one access at a time to a fixed-latency RAM, with priority to the memory cycle stage. Returns read data with a one-cycle valid pulse and drives a pipeline stall while any requester is waiting. Sits between the pipeline stages and the RAM macro.

## Interface
- LAT, 2: RAM read/write latency in cycles, from the `ram_en` cycle to valid `ram_rdata`; legal range ≥1.
- ADDR_W, 32: address width.
- DATA_W, 32: data width.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-low reset.
- if_req  in  1  fetch read request; held until `if_valid`.
- if_addr  in  ADDR_W  fetch address.
- if_valid  out  1  one-cycle pulse: `if_rdata` valid.
- if_rdata  out  DATA_W  fetch read data.
- mem_rd  in  1  memory-stage read request; held until `mem_valid`.
- mem_wr  in  1  memory-stage write request; held until `mem_valid`.
- mem_addr  in  ADDR_W  memory-stage address (ALU result).
- mem_wdata  in  DATA_W  write data.
- mem_valid  out  1  one-cycle pulse: access complete; `mem_rdata` valid for reads.
- mem_rdata  out  DATA_W  read data.
- stall  out  1  freeze pipeline.
- ram_en  out  1  one-cycle access strobe.
- ram_we  out  1  write enable; qualified by `ram_en`.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data; valid LAT cycles after `ram_en`.

## Operation
- FSM states are IDLE, WAIT and RESP.
- IDLE:
  - If `mem_rd` or `mem_wr` is high, issue a MEM access.
  - Otherwise, if `if_req` is high, issue an IF access.
  - Otherwise, stay in IDLE.
- Issue cycle (combinational, in IDLE):
  - `ram_en`=1.
  - `ram_addr` comes from the winner's address.
  - `ram_we` = `mem_wr` for MEM and 0 for IF.
  - `ram_wdata` = `mem_wdata`.
  - Register the owner, load the counter with LAT, and go to WAIT.
- WAIT: decrement the counter each cycle. When the counter is 1, capture `ram_rdata` into the response register and go to RESP.
- RESP:
  - Pulse the owner's valid output. Drive the captured data on its rdata output, or 0 for writes.
  - Go to IDLE. No issue takes place in RESP.
- `mem_rd` and `mem_wr` high together: treated as a write.
- Priority is fixed, MEM over IF. IF cannot starve, because a served MEM stage advances and drops its request.
- Request withdrawn mid-access: the access still completes and the valid pulse is still produced. Requester ignores it.
- `stall` = (`if_req` & ~`if_valid`) | ((`mem_rd`|`mem_wr`) & ~`mem_valid`). It is combinational.
- `if_rdata` and `mem_rdata` hold their last value between pulses.

## Timing
- Issue at cycle t:
  - WAIT covers t+1 … t+LAT.
  - `ram_rdata` is captured at the end of t+LAT.
  - The valid pulse is in t+LAT+1 (RESP).
  - Earliest next issue is t+LAT+2.
- Occupancy is LAT+2 cycles per access. For LAT=2, valid comes at t+3 and the next issue at t+4.
- Counter width is $clog2(LAT+1). The counter never wraps: it is loaded only in IDLE and exits at 1.
- Reset (`rst`=0 at a clock edge), from any state:
  - Next state is IDLE; counter and response registers are 0.
  - `if_valid`, `mem_valid`, `ram_en`, `ram_we` are 0.
  - `if_rdata`, `mem_rdata`, `ram_addr`, `ram_wdata` are 0.
  - An in-flight RAM result is discarded and no valid pulse is produced.
- `stall` during reset follows its equation with both valids at 0.
- First issue is possible in the first cycle with `rst`=1.

## Structure
- Package `mem_arb_pkg`:
  - State enum {IDLE, WAIT, RESP}.
  - Owner enum {OWN_IF, OWN_MEM}.
  - Default LAT constant.
- Sub-module `mem_arb_timer`: loadable down-counter with a `done` flag at count 1, parameterised by LAT. The FSM, arbitration and response register stay in `mem_arbiter`.

## Test plan
(All scenarios use LAT=2.)
- **Reset:** hold `rst`=0 for 2 cycles with `mem_rd`=1 → `ram_en`=0 and both valids 0. After release, the issue happens in the first cycle.
- **MEM write:** `mem_wr`=1, `mem_addr`=10, `mem_wdata`=100 at t →
  - t: `ram_en`=1, `ram_we`=1, `ram_addr`=10, `ram_wdata`=100.
  - `mem_valid` at t+3 only.
  - `stall`=1 for t…t+2 and 0 at t+3.
- **MEM read:** `mem_rd`=1, `mem_addr`=10 after the write → `ram_we`=0; `mem_valid`=1 and `mem_rdata`=100 at t+3; `if_valid` stays 0.
- **Contention:** `if_req`=1 with `if_addr`=0x40, and `mem_rd`=1 with `mem_addr`=20, both at t →
  - MEM issued at t, with `mem_valid` at t+3.
  - IF issued at t+4 with `ram_addr`=0x40, and `if_valid` at t+7.
- **Reset mid-access:** `mem_rd` issued at t, `rst`=0 at t+1 → no `mem_valid` at t+3, FSM in IDLE. A new read after release completes in 3 cycles.
- **Both flags:** `mem_rd`=`mem_wr`=1, `mem_addr`=20, `mem_wdata`=200 → `ram_we`=1; a subsequent read of 20 returns 200.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter: FSM states,
// access owner encoding and the default RAM latency.
package mem_arb_pkg;

   localparam int DEFAULT_LAT = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   typedef enum logic {
      OWN_IF  = 1'b0,
      OWN_MEM = 1'b1
   } owner_t;

endpackage

// File: rtl/mem_arb_timer.sv
// Loadable down-counter that times one RAM access; done is raised while
// the count sits at 1, i.e. in the cycle where RAM read data is valid.
module mem_arb_timer #(
   parameter int LAT = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic dec,
   output logic done
);

   localparam int CW = $clog2(LAT + 1);

   logic [CW-1:0] count_r;

   // Load on issue, count down while waiting; stops at zero so it never wraps.
   always_ff @(posedge clk) begin
      if (!rst) begin
         count_r <= {CW{1'b0}};
      end else if (load) begin
         count_r <= CW'(LAT);
      end else if (dec && (count_r != {CW{1'b0}})) begin
         count_r <= count_r - CW'(1);
      end else begin
         count_r <= count_r;
      end
   end

   assign done = (count_r == CW'(1));

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter/sequencer for the single-port data RAM shared by instruction fetch
// and the memory stage; MEM has fixed priority, one access in flight at a time.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int LAT    = DEFAULT_LAT,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_valid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              mem_rd,
   input  logic              mem_wr,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic              mem_valid,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              stall,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   state_t            state_r;
   state_t            state_nx;
   owner_t            owner_r;
   logic              write_r;
   logic              if_valid_r;
   logic              mem_valid_r;
   logic [DATA_W-1:0] if_rdata_r;
   logic [DATA_W-1:0] mem_rdata_r;
   logic              issue_s;
   logic              issue_mem_s;
   logic              done_s;
   logic              mem_any_s;

   assign mem_any_s = mem_rd | mem_wr;

   mem_arb_timer #(
      .LAT (LAT)
   ) u_timer (
      .clk  (clk),
      .rst  (rst),
      .load (issue_s),
      .dec  (state_r == WAIT),
      .done (done_s)
   );

   // Next-state and issue decision; the issue is suppressed while reset is held.
   always_comb begin
      state_nx    = state_r;
      issue_s     = 1'b0;
      issue_mem_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (rst && mem_any_s) begin
               issue_s     = 1'b1;
               issue_mem_s = 1'b1;
               state_nx    = WAIT;
            end else if (rst && if_req) begin
               issue_s  = 1'b1;
               state_nx = WAIT;
            end else begin
               state_nx = IDLE;
            end
         end
         WAIT: begin
            if (done_s) begin
               state_nx = RESP;
            end else begin
               state_nx = WAIT;
            end
         end
         RESP:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // RAM strobe and payload for the issue cycle; a simultaneous rd+wr is a write.
   always_comb begin
      ram_en    = issue_s;
      ram_we    = issue_s & issue_mem_s & mem_wr;
      ram_addr  = {ADDR_W{1'b0}};
      ram_wdata = {DATA_W{1'b0}};
      if (issue_s) begin
         ram_addr  = issue_mem_s ? mem_addr : if_addr;
         ram_wdata = mem_wdata;
      end else begin
         ram_addr  = {ADDR_W{1'b0}};
         ram_wdata = {DATA_W{1'b0}};
      end
   end

   // State, owner and response registers; valid pulses are set on entry to RESP.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r     <= IDLE;
         owner_r     <= OWN_IF;
         write_r     <= 1'b0;
         if_valid_r  <= 1'b0;
         mem_valid_r <= 1'b0;
         if_rdata_r  <= {DATA_W{1'b0}};
         mem_rdata_r <= {DATA_W{1'b0}};
      end else begin
         state_r     <= state_nx;
         if_valid_r  <= 1'b0;
         mem_valid_r <= 1'b0;
         if (issue_s) begin
            owner_r <= issue_mem_s ? OWN_MEM : OWN_IF;
            write_r <= issue_mem_s & mem_wr;
         end
         if ((state_r == WAIT) && done_s) begin
            if (owner_r == OWN_MEM) begin
               mem_valid_r <= 1'b1;
               mem_rdata_r <= write_r ? {DATA_W{1'b0}} : ram_rdata;
            end else begin
               if_valid_r <= 1'b1;
               if_rdata_r <= ram_rdata;
            end
         end
      end
   end

   assign if_valid  = if_valid_r;
   assign mem_valid = mem_valid_r;
   assign if_rdata  = if_rdata_r;
   assign mem_rdata = mem_rdata_r;
   assign stall     = (if_req & ~if_valid_r) | (mem_any_s & ~mem_valid_r);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a behavioural RAM, directed scenarios and
// random IF/MEM traffic; a negedge monitor compares everything against queues.
module tb_mem_arbiter;

   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = 32'd0;
   logic        if_valid;
   logic [31:0] if_rdata;
   logic        mem_rd = 1'b0;
   logic        mem_wr = 1'b0;
   logic [31:0] mem_addr = 32'd0;
   logic [31:0] mem_wdata = 32'd0;
   logic        mem_valid;
   logic [31:0] mem_rdata;
   logic        stall;
   logic        ram_en;
   logic        ram_we;
   logic [31:0] ram_addr;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata;

   always #5 clk = ~clk;

   mem_arbiter #(.LAT(LAT), .ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_valid(mem_valid), .mem_rdata(mem_rdata), .stall(stall),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata)
   );

   function automatic logic [31:0] init_val(input logic [31:0] a);
      return (a * 32'd2654435761) ^ 32'h5A5A_0000;
   endfunction

   // Behavioural fixed-latency RAM (addresses 0..127)
   logic [31:0] ram_mem [0:127];
   logic [31:0] rpipe [LAT];
   logic        ram_ready = 1'b0;

   always @(posedge clk) begin
      if (!ram_ready) begin
         for (int i = 0; i < 128; i++) ram_mem[i] <= init_val(32'(i));
         ram_ready <= 1'b1;
      end else if (ram_en && ram_we) begin
         ram_mem[ram_addr[6:0]] <= ram_wdata;
      end
      rpipe[0] <= ram_en ? ram_mem[ram_addr[6:0]] : 32'hDEAD_BEEF;
      for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
   end
   assign ram_rdata = rpipe[LAT-1];

   // Reference model and scoreboard state
   logic [31:0] model_mem [0:127];
   logic [31:0] mem_q [$];
   logic [31:0] if_q [$];
   int          mem_iss_q [$];
   int          if_iss_q [$];
   int          compared = 0;
   int          failed = 0;
   int          timeouts = 0;
   int          cyc = 0;
   int          rst_run = 0;
   logic        seen_rst = 1'b0;
   logic        end_req = 1'b0;
   int          last_iss = -1000;
   logic [31:0] last_if = 32'd0;
   logic [31:0] last_mem = 32'd0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge clk) begin
      cyc     <= cyc + 1;
      rst_run <= rst ? 0 : rst_run + 1;
      if (!rst) seen_rst <= 1'b1;
   end

   // Monitor: checks all DUT outputs half a cycle after each active edge
   always @(negedge clk) begin
      if (seen_rst) begin
         chk("stall", stall, (if_req & ~if_valid) | ((mem_rd | mem_wr) & ~mem_valid));
         if (!rst) begin
            chk("rst_ram_en", ram_en, 0);
            chk("rst_ram_we", ram_we, 0);
            chk("rst_ram_addr", ram_addr, 0);
            chk("rst_ram_wdata", ram_wdata, 0);
            if (rst_run > 0) begin
               chk("rst_if_valid", if_valid, 0);
               chk("rst_mem_valid", mem_valid, 0);
               chk("rst_if_rdata", if_rdata, 0);
               chk("rst_mem_rdata", mem_rdata, 0);
            end
            last_iss = -1000;
            last_if  = 32'd0;
            last_mem = 32'd0;
            mem_iss_q.delete();
            if_iss_q.delete();
         end else begin
            if (mem_valid) begin
               chk("mem_valid_expected", 32'(mem_q.size() != 0), 1);
               if (mem_q.size() != 0) chk("mem_rdata", mem_rdata, mem_q.pop_front());
               if (mem_iss_q.size() != 0) chk("mem_latency", cyc - mem_iss_q.pop_front(), LAT + 1);
               last_mem = mem_rdata;
            end else begin
               chk("mem_rdata_hold", mem_rdata, last_mem);
            end
            if (if_valid) begin
               chk("if_valid_expected", 32'(if_q.size() != 0), 1);
               if (if_q.size() != 0) chk("if_rdata", if_rdata, if_q.pop_front());
               if (if_iss_q.size() != 0) chk("if_latency", cyc - if_iss_q.pop_front(), LAT + 1);
               last_if = if_rdata;
            end else begin
               chk("if_rdata_hold", if_rdata, last_if);
            end
            if (ram_en) begin
               chk("issue_spacing", 32'(cyc - last_iss >= LAT + 2), 1);
               if (mem_rd | mem_wr) begin
                  chk("mem_ram_addr", ram_addr, mem_addr);
                  chk("mem_ram_we", ram_we, mem_wr);
                  chk("mem_ram_wdata", ram_wdata, mem_wdata);
                  mem_iss_q.push_back(cyc);
               end else if (if_req) begin
                  chk("if_ram_addr", ram_addr, if_addr);
                  chk("if_ram_we", ram_we, 0);
                  if_iss_q.push_back(cyc);
               end else begin
                  chk("spurious_issue", ram_en, 0);
               end
               last_iss = cyc;
            end else if ((mem_rd | mem_wr | if_req) && (cyc - last_iss >= LAT + 2)) begin
               chk("missed_issue", ram_en, 1);
            end
         end
      end
      if (end_req) begin
         chk("mem_q_drained", mem_q.size(), 0);
         chk("if_q_drained", if_q.size(), 0);
         chk("no_timeouts", timeouts, 0);
         $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
         $finish;
      end
   end

   task automatic mem_start(input logic wr, input logic rd, input logic [31:0] a, input logic [31:0] d);
      mem_wr    = wr;
      mem_rd    = rd;
      mem_addr  = a;
      mem_wdata = d;
      if (wr) begin
         model_mem[a[6:0]] = d;
         mem_q.push_back(32'd0);
      end else begin
         mem_q.push_back(model_mem[a[6:0]]);
      end
   endtask

   task automatic mem_finish();
      logic got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
         @(negedge clk);
         if (mem_valid) got = 1'b1;
      end
      if (!got) begin
         timeouts++;
         $display("FAIL mem_valid_timeout: got no pulse within 20 cycles, required one (addr %h)", mem_addr);
      end
      @(posedge clk);
      #1;
      mem_rd = 1'b0;
      mem_wr = 1'b0;
   endtask

   task automatic mem_access(input logic wr, input logic rd, input logic [31:0] a, input logic [31:0] d);
      @(posedge clk);
      #1;
      mem_start(wr, rd, a, d);
      mem_finish();
   endtask

   task automatic if_start(input logic [31:0] a);
      if_req  = 1'b1;
      if_addr = a;
      if_q.push_back(init_val(a));
   endtask

   task automatic if_finish();
      logic got = 1'b0;
      for (int k = 0; k < 40 && !got; k++) begin
         @(negedge clk);
         if (if_valid) got = 1'b1;
      end
      if (!got) begin
         timeouts++;
         $display("FAIL if_valid_timeout: got no pulse within 40 cycles, required one (addr %h)", if_addr);
      end
      @(posedge clk);
      #1;
      if_req = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 128; i++) model_mem[i] = init_val(32'(i));
      // Reset held two cycles with a pending MEM read; issue on first released cycle
      mem_rd   = 1'b1;
      mem_addr = 32'd5;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      mem_q.push_back(model_mem[5]);
      mem_finish();
      // Write then read back
      mem_access(1'b1, 1'b0, 32'd10, 32'd100);
      mem_access(1'b0, 1'b1, 32'd10, 32'd0);
      // Contention: MEM wins, IF follows
      @(posedge clk);
      #1;
      fork
         begin mem_start(1'b0, 1'b1, 32'd20, 32'd0); mem_finish(); end
         begin if_start(32'h40); if_finish(); end
      join
      // Reset in the middle of a read: no pulse may follow
      @(posedge clk);
      #1;
      mem_start(1'b0, 1'b1, 32'd10, 32'd0);
      @(posedge clk);
      #1;
      rst    = 1'b0;
      mem_rd = 1'b0;
      mem_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      mem_access(1'b0, 1'b1, 32'd10, 32'd0);
      // Read and write together act as a write
      mem_access(1'b1, 1'b1, 32'd20, 32'd200);
      mem_access(1'b0, 1'b1, 32'd20, 32'd0);
      // Random concurrent traffic
      fork
         begin
            for (int n = 0; n < 40; n++) begin
               repeat ($urandom_range(0, 3)) @(posedge clk);
               case ($urandom_range(0, 2))
                  0:       mem_access(1'b0, 1'b1, 32'($urandom_range(0, 63)), 32'd0);
                  1:       mem_access(1'b1, 1'b0, 32'($urandom_range(0, 63)), $urandom);
                  default: mem_access(1'b1, 1'b1, 32'($urandom_range(0, 63)), $urandom);
               endcase
            end
         end
         begin
            for (int m = 0; m < 40; m++) begin
               repeat ($urandom_range(0, 3)) @(posedge clk);
               @(posedge clk);
               #1;
               if_start(32'($urandom_range(64, 127)));
               if_finish();
            end
         end
      join
      repeat (5) @(posedge clk);
      end_req = 1'b1;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within 100000 time units");
      $fatal(1, "watchdog expired");
   end

endmodule
